div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_abs.sv | 20 ++
 rtl/div_iter.sv | 151 +++++++++++++++
 tb/tb_div_iter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared FSM state encoding and default width for the divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_abs.sv
// ============================================================================
// Module  : div_abs
// Purpose : Conditional two's-complement negate (magnitude / sign fixup).
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_abs #(
   parameter int WIDTH = 32
) (
   input  logic             neg_i,
   input  logic [WIDTH-1:0] val_i,
   output logic [WIDTH-1:0] val_o
);

   assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module  : div_iter
// Purpose : Iterative restoring divider, one quotient bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] qres_q, qres_d;
   logic [WIDTH-1:0] rres_q, rres_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             dz_q, dz_d;

   logic             accept;
   logic             last_iter;
   logic             present;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix, q_final;

   assign accept    = (state_q == S_IDLE) && start && !flush;
   assign last_iter = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));
   assign present   = (state_q == S_DONE) && !flush;

   div_abs #(.WIDTH(WIDTH)) u_abs_a (.neg_i(sign & a[WIDTH-1]), .val_i(a),     .val_o(a_mag));
   div_abs #(.WIDTH(WIDTH)) u_abs_b (.neg_i(sign & b[WIDTH-1]), .val_i(b),     .val_o(b_mag));
   div_abs #(.WIDTH(WIDTH)) u_fix_q (.neg_i(sa_q ^ sb_q),       .val_i(quo_q), .val_o(q_fix));
   div_abs #(.WIDTH(WIDTH)) u_fix_r (.neg_i(sa_q),              .val_i(rem_q), .val_o(r_fix));

   // Zero divisor: the magnitude loop already yields all-ones/|a|; only the
   // quotient sign fixup must be suppressed.
   assign q_final = dz_q ? '1 : q_fix;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start)     state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      valid     = present;
      quotient  = present ? q_final : qres_q;
      remainder = present ? r_fix   : rres_q;
   end

   // ---------------------------------------------------------------- datapath
   assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

   always_comb begin
      cnt_d  = cnt_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      dz_d   = dz_q;
      qres_d = qres_q;
      rres_d = rres_q;
      if (accept) begin
         cnt_d = '0;
         quo_d = a_mag;
         rem_d = '0;
         dvs_d = b_mag;
         sa_d  = sign & a[WIDTH-1];
         sb_d  = sign & b[WIDTH-1];
         dz_d  = (b == '0);
      end else if ((state_q == S_RUN) && !flush) begin
         cnt_d = cnt_q + CW'(1);
         if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
      if (present) begin
         qres_d = q_final;
         rres_d = r_fix;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         dz_q   <= 1'b0;
         qres_q <= '0;
         rres_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         dz_q   <= dz_d;
         qres_q <= qres_d;
         rres_q <= rres_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
// Module  : tb_div_iter
// Purpose : Scoreboard bench for div_iter with directed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b1;
   logic         flush = 1'b0;
   logic         start = 1'b0;
   logic         sign = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, valid;
   logic [W-1:0] quotient, remainder;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int valid_cnt = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           c;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   div_iter #(.WIDTH(W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .start     (start),
      .sign      (sign),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .valid     (valid),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per valid pulse; latency counts the
   // cycle in which start was sampled as cycle 0.
   always @(negedge clk) begin
      if (valid) begin
         valid_cnt++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got q=%h r=%h required no valid", quotient, remainder);
         end else begin
            mon_e = sb.pop_front();
            check("quotient", quotient, mon_e.q);
            check("remainder", remainder, mon_e.r);
            check("latency", W'(cyc - mon_e.c), W'(W + 1));
         end
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input logic push, input logic [W-1:0] eq, input logic [W-1:0] er);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: got busy=1 required busy=0");
      end
      a = ia; b = ib; sign = is; start = 1'b1;
      if (push) sb.push_back('{eq, er, cyc});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int v0;
      #2 resetn = 1'b0;
      @(negedge clk);
      check("reset_busy", W'(busy), W'(0));
      check("reset_valid", W'(valid), W'(0));
      check("reset_quotient", quotient, '0);
      check("reset_remainder", remainder, '0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Basic unsigned, then pulse width / return to idle
      issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2);
      drain();
      @(negedge clk);
      check("valid_pulse_width", W'(valid), W'(0));
      check("idle_after_done", W'(busy), W'(0));

      issue(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
      issue(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFD, 32'd1);
      issue(32'h12345678, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h12345678);
      issue(32'hFFFFFFFB, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB);
      issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 32'd0);
      issue(32'h80000000, 32'd3, 1'b0, 1'b1, 32'h2AAAAAAA, 32'd2);
      drain();

      // Flush at iteration 10: no valid, prior result held
      issue(32'd1000, 32'd3, 1'b0, 1'b0, '0, '0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", W'(busy), W'(0));
      check("flush_valid", W'(valid), W'(0));
      check("flush_hold_q", quotient, 32'h2AAAAAAA);
      check("flush_hold_r", remainder, 32'd2);
      repeat (40) @(negedge clk);
      issue(32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0);
      drain();
      repeat (2) @(negedge clk);

      // Start held high for 100 cycles: accepted every W+2 cycles
      v0 = valid_cnt;
      for (int i = 0; i < 100; i++) begin
         a = 32'd50; b = 32'd5; sign = 1'b0; start = 1'b1;
         if (i % (W + 2) == 0) sb.push_back('{32'd10, 32'd0, cyc});
         @(negedge clk);
      end
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check("stream_valid_count", W'(valid_cnt - v0), W'(3));

      // Asynchronous reset at iteration 20
      issue(32'd1000, 32'd7, 1'b0, 1'b0, '0, '0);
      repeat (20) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("arst_busy", W'(busy), W'(0));
      check("arst_valid", W'(valid), W'(0));
      check("arst_quotient", quotient, '0);
      check("arst_remainder", remainder, '0);
      @(negedge clk);
      resetn = 1'b1;
      v0 = valid_cnt;
      repeat (50) @(negedge clk);
      check("arst_no_valid", W'(valid_cnt - v0), W'(0));

      issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2);
      drain();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
